btn_cmd_arbiter: RTL and testbench

- Shares one command-execution datapath among NUM_REQ push-button requesters.
- Each requester is a debounced, active-high button level. A press-and-release counts as one command request; the command fires on release.
- Requests are latched, then granted round-robin. Each grant is issued as a one-cycle start pulse, and the arbiter waits for done, with a timeout guard.
- Sits between the button input conditioning and the shared operation unit (ALU/display sequencer).

---
 rtl/btn_arb_pkg.sv | 13 +
 rtl/release_detect.sv | 23 ++
 rtl/btn_cmd_arbiter.sv | 84 ++++++++
 tb/tb_btn_cmd_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_arb_pkg.sv
// btn_arb_pkg: shared state encoding and default sizing for the button command arbiter
package btn_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/release_detect.sv
// release_detect: turns a button release (1 -> 0) into a sticky pending flag
module release_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic clr,
    output logic pend
);

    logic prev_level;

    // track the previous level; a fresh release beats a grant's clear so it is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_level <= 1'b0;
            pend       <= 1'b0;
        end else begin
            prev_level <= level;
            pend       <= (prev_level && !level) ? 1'b1 : (clr ? 1'b0 : pend);
        end
    end

endmodule

// File: rtl/btn_cmd_arbiter.sv
// btn_cmd_arbiter: round-robin grant of latched button commands onto one shared operation unit
module btn_cmd_arbiter
    import btn_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_level,
    input  logic                       op_done,
    output logic                       op_start,
    output logic [$clog2(NUM_REQ)-1:0] op_sel,
    output logic                       busy,
    output logic [NUM_REQ-1:0]         pending,
    output logic                       timeout
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state;
    logic [SEL_W-1:0]   last_grant;
    logic [SEL_W-1:0]   winner;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] clr;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rd
        release_detect u_rd (
            .clk   (clk),
            .reset (reset),
            .level (req_level[i]),
            .clr   (clr[i]),
            .pend  (pending[i])
        );
    end

    // lowest pending index overall, overridden by the lowest pending index above last_grant (wrap-around search)
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pending[i]) winner = SEL_W'(i);
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (pending[i] && SEL_W'(i) > last_grant) winner = SEL_W'(i);
    end

    // clear the winner's pending bit on the grant edge; outputs decoded from state
    always_comb begin
        clr = '0;
        if (state == IDLE && |pending) clr[winner] = 1'b1;
        op_start = (state == START);
        busy     = (state == START) || (state == WAIT_DONE);
        timeout  = (state == WAIT_DONE) && !op_done && (cnt == CNT_MAX);
    end

    // grant FSM with done/timeout handling; done beats timeout in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_sel     <= '0;
            last_grant <= SEL_W'(NUM_REQ - 1);
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: if (|pending) begin
                    op_sel     <= winner;
                    last_grant <= winner;
                    state      <= START;
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (op_done || cnt == CNT_MAX) state <= IDLE;
                    cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// tb_btn_cmd_arbiter: vector table plus directed multi-cycle sequences for btn_cmd_arbiter
module tb_btn_cmd_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_level = 4'b0000;
    logic       op_done = 1'b0;
    logic       op_start;
    logic [1:0] op_sel;
    logic       busy;
    logic [3:0] pending;
    logic       timeout;

    int total = 0;
    int bad = 0;
    int grants[$];

    btn_cmd_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_level (req_level),
        .op_done   (op_done),
        .op_start  (op_start),
        .op_sel    (op_sel),
        .busy      (busy),
        .pending   (pending),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (op_start) grants.push_back(int'(op_sel));

    typedef struct {
        logic       rst;
        logic [3:0] lvl;
        logic       done;
        logic       st;
        logic [1:0] sel;
        logic       bsy;
        logic [3:0] pnd;
        logic       to;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic r, logic [3:0] l, logic d, logic s, logic [1:0] se,
                                logic b, logic [3:0] p, logic t);
        vec_t v;
        v.rst = r; v.lvl = l; v.done = d; v.st = s; v.sel = se; v.bsy = b; v.pnd = p; v.to = t;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] lvl);
        reset = 1'b1; req_level = lvl; op_done = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        // single press/release of requester 2 with done three cycles after the start pulse
        vecs[0]  = mk(1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        vecs[1]  = mk(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        vecs[2]  = mk(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        vecs[3]  = mk(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        vecs[4]  = mk(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        vecs[5]  = mk(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        vecs[6]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b0);
        vecs[7]  = mk(1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0);
        vecs[8]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000, 1'b0);
        vecs[9]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000, 1'b0);
        vecs[10] = mk(1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0);
        vecs[11] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 1'b0);

        for (int k = 0; k < 12; k++) begin
            reset = vecs[k].rst; req_level = vecs[k].lvl; op_done = vecs[k].done;
            step();
            chk($sformatf("v%0d.op_start", k), 8'(op_start), 8'(vecs[k].st));
            chk($sformatf("v%0d.op_sel", k),   8'(op_sel),   8'(vecs[k].sel));
            chk($sformatf("v%0d.busy", k),     8'(busy),     8'(vecs[k].bsy));
            chk($sformatf("v%0d.pending", k),  8'(pending),  8'(vecs[k].pnd));
            chk($sformatf("v%0d.timeout", k),  8'(timeout),  8'(vecs[k].to));
        end
        op_done = 1'b0;

        // fairness: 0 and 3 released together, 0 re-released during its own grant -> 0,3,0
        do_reset(4'b0000);
        grants.delete();
        req_level = 4'b1001; step();
        req_level = 4'b0000; step();
        chk("fair.pend_both", 8'(pending), 8'h9);
        step();
        chk("fair.g1_start", 8'(op_start), 8'h1);
        chk("fair.g1_sel", 8'(op_sel), 8'h0);
        req_level = 4'b0001; step();
        req_level = 4'b0000; step();
        chk("fair.rerelease_pend", 8'(pending), 8'h9);
        op_done = 1'b1; step(); op_done = 1'b0;
        step();
        chk("fair.g2_sel", 8'(op_sel), 8'h3);
        chk("fair.g2_start", 8'(op_start), 8'h1);
        step();
        op_done = 1'b1; step(); op_done = 1'b0;
        step();
        chk("fair.g3_sel", 8'(op_sel), 8'h0);
        step();
        op_done = 1'b1; step(); op_done = 1'b0;
        step();
        chk("fair.idle_busy", 8'(busy), 8'h0);
        chk("fair.idle_pend", 8'(pending), 8'h0);
        chk("fair.count", 8'(grants.size()), 8'h3);
        if (grants.size() == 3) begin
            chk("fair.order0", 8'(grants[0]), 8'h0);
            chk("fair.order1", 8'(grants[1]), 8'h3);
            chk("fair.order2", 8'(grants[2]), 8'h0);
        end

        // timeout: no done for requester 0, requester 1 waits and is granted afterwards
        do_reset(4'b0000);
        req_level = 4'b0001; step();
        req_level = 4'b0000; step();
        step();
        chk("to.start", 8'(op_start), 8'h1);
        req_level = 4'b0010; step();
        chk("to.early1", 8'(timeout), 8'h0);
        req_level = 4'b0000; step();
        chk("to.early2", 8'(timeout), 8'h0);
        cyc = 2;
        while (cyc < 20 && !timeout) begin
            step();
            cyc++;
        end
        chk("to.cycles_after_start", 8'(cyc), 8'd8);
        step();
        chk("to.pulse_once", 8'(timeout), 8'h0);
        chk("to.idle_busy", 8'(busy), 8'h0);
        chk("to.pend_other", 8'(pending), 8'h2);
        step();
        chk("to.next_start", 8'(op_start), 8'h1);
        chk("to.next_sel", 8'(op_sel), 8'h1);
        step();
        op_done = 1'b1; step(); op_done = 1'b0;

        // held through reset, then released: exactly one grant to 1
        do_reset(4'b0010);
        grants.delete();
        step();
        step();
        chk("held.no_pend", 8'(pending), 8'h0);
        req_level = 4'b0000; step();
        chk("held.pend", 8'(pending), 8'h2);
        step();
        chk("held.sel", 8'(op_sel), 8'h1);
        step();
        op_done = 1'b1; step(); op_done = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("held.one_grant", 8'(grants.size()), 8'h1);

        // release in the very first cycle after reset is not a request
        do_reset(4'b0010);
        grants.delete();
        req_level = 4'b0000;
        for (int k = 0; k < 4; k++) step();
        chk("first.pend", 8'(pending), 8'h0);
        chk("first.no_grant", 8'(grants.size()), 8'h0);

        // set-over-clear: requester 0 released on the edge it is granted
        do_reset(4'b0000);
        req_level = 4'b0010; step();
        req_level = 4'b0000; step();
        step();
        chk("soc.g1_sel", 8'(op_sel), 8'h1);
        req_level = 4'b0001; step();
        req_level = 4'b0000; step();
        req_level = 4'b0001; step();
        op_done = 1'b1; step(); op_done = 1'b0;
        req_level = 4'b0000; step();
        chk("soc.start0", 8'(op_start), 8'h1);
        chk("soc.sel0", 8'(op_sel), 8'h0);
        chk("soc.pend_kept", 8'(pending), 8'h1);
        step();
        op_done = 1'b1; step(); op_done = 1'b0;
        chk("soc.idle_pend", 8'(pending), 8'h1);
        step();
        chk("soc.regrant_start", 8'(op_start), 8'h1);
        chk("soc.regrant_sel", 8'(op_sel), 8'h0);
        chk("soc.regrant_pend", 8'(pending), 8'h0);
        step();
        op_done = 1'b1; step(); op_done = 1'b0;

        // reset during WAIT_DONE with 1 and 3 pending drops everything
        do_reset(4'b0000);
        req_level = 4'b0001; step();
        req_level = 4'b0000; step();
        step();
        req_level = 4'b1010; step();
        req_level = 4'b0000; step();
        chk("mid.pend_before", 8'(pending), 8'hA);
        chk("mid.busy_before", 8'(busy), 8'h1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid.pend", 8'(pending), 8'h0);
        chk("mid.busy", 8'(busy), 8'h0);
        chk("mid.start0", 8'(op_start), 8'h0);
        step();
        chk("mid.start1", 8'(op_start), 8'h0);
        step();
        chk("mid.start2", 8'(op_start), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
